// File: rtl/regfile_read_arbiter.sv
// Round-robin owner of the register-file read selector: serves NREQ single-address
// readers and a debug scan that streams all 2**AW entries out on a valid/ready port.
module regfile_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    input  logic               scan_start,
    output logic               scan_valid,
    input  logic               scan_ready,
    output logic [AW-1:0]      scan_idx,
    output logic [DW-1:0]      scan_data,
    output logic               scan_done,
    output logic               busy,
    output logic               sel_ena,
    output logic [AW-1:0]      sel_idx,
    input  logic [DW-1:0]      sel_data
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW-1:0] LAST_RESET = GW'(NREQ - 1);

    typedef enum logic [1:0] {ARB, READ, SCAN_RD, SCAN_OUT} stateT;

    stateT           state, stateNext;
    logic [GW-1:0]   lastGnt, lastGntNext;
    logic [GW-1:0]   gnt, gntNext;
    logic [GW-1:0]   pick;
    logic            scanPend, scanPendNext;
    logic [AW-1:0]   scanPtr, scanPtrNext;
    logic [NREQ-1:0] eligible;
    logic [AW-1:0]   pickAddr;
    logic [NREQ-1:0] rspValidNext;
    logic [DW-1:0]   rspDataNext;
    logic            scanValidNext;
    logic [AW-1:0]   scanIdxNext;
    logic [DW-1:0]   scanDataNext;
    logic            scanDoneNext;
    logic            selEnaNext;
    logic [AW-1:0]   selIdxNext;
    logic            scanning;

    // First eligible requester strictly after the last one served, wrapping at NREQ-1.
    function automatic logic [GW-1:0] rrPick(input logic [NREQ-1:0] elig,
                                             input logic [GW-1:0]   last);
        logic [GW-1:0] cand;
        logic          found;
        rrPick = last;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last) + k) % NREQ);
            if (!found && elig[cand]) begin
                rrPick = cand;
                found  = 1'b1;
            end
        end
    endfunction

    // A requester whose response is on the bus this cycle must not be regranted.
    assign eligible = req_valid & ~rsp_valid;
    assign pick     = rrPick(eligible, lastGnt);
    assign busy     = (state != ARB);
    assign scanning = (state == SCAN_RD) || (state == SCAN_OUT);

    always_comb begin
        pickAddr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == GW'(i)) begin
                pickAddr = req_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        stateNext     = state;
        lastGntNext   = lastGnt;
        gntNext       = gnt;
        scanPendNext  = scanPend;
        scanPtrNext   = scanPtr;
        rspValidNext  = '0;
        rspDataNext   = rsp_data;
        scanValidNext = scan_valid;
        scanIdxNext   = scan_idx;
        scanDataNext  = scan_data;
        scanDoneNext  = 1'b0;
        selEnaNext    = 1'b0;
        selIdxNext    = sel_idx;

        if (scan_start && !scanning) begin
            scanPendNext = 1'b1;
        end

        // sel_ena is registered, so it is raised exactly for the READ and SCAN_RD cycles.
        unique case (state)
            ARB: begin
                if (scanPend || scan_start) begin
                    stateNext    = SCAN_RD;
                    scanPtrNext  = '0;
                    scanPendNext = 1'b0;
                    selEnaNext   = 1'b1;
                    selIdxNext   = '0;
                end else if (|eligible) begin
                    stateNext  = READ;
                    gntNext    = pick;
                    selEnaNext = 1'b1;
                    selIdxNext = pickAddr;
                end
            end
            READ: begin
                rspDataNext       = sel_data;
                rspValidNext[gnt] = 1'b1;
                lastGntNext       = gnt;
                stateNext         = ARB;
            end
            SCAN_RD: begin
                scanDataNext  = sel_data;
                scanIdxNext   = scanPtr;
                scanValidNext = 1'b1;
                stateNext     = SCAN_OUT;
            end
            SCAN_OUT: begin
                if (scan_ready) begin
                    scanValidNext = 1'b0;
                    if (scanPtr == '1) begin
                        scanDoneNext = 1'b1;
                        scanPtrNext  = '0;
                        stateNext    = ARB;
                    end else begin
                        scanPtrNext = scanPtr + 1'b1;
                        selEnaNext  = 1'b1;
                        selIdxNext  = scanPtr + 1'b1;
                        stateNext   = SCAN_RD;
                    end
                end
            end
            default: stateNext = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            lastGnt    <= LAST_RESET;
            gnt        <= '0;
            scanPend   <= 1'b0;
            scanPtr    <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            scan_valid <= 1'b0;
            scan_idx   <= '0;
            scan_data  <= '0;
            scan_done  <= 1'b0;
            sel_ena    <= 1'b0;
            sel_idx    <= '0;
        end else begin
            state      <= stateNext;
            lastGnt    <= lastGntNext;
            gnt        <= gntNext;
            scanPend   <= scanPendNext;
            scanPtr    <= scanPtrNext;
            rsp_valid  <= rspValidNext;
            rsp_data   <= rspDataNext;
            scan_valid <= scanValidNext;
            scan_idx   <= scanIdxNext;
            scan_data  <= scanDataNext;
            scan_done  <= scanDoneNext;
            sel_ena    <= selEnaNext;
            sel_idx    <= selIdxNext;
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of round-robin service and the scan stream.
module tb_regfile_read_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam logic [DW-1:0] ENTRY_BASE = 32'hA500_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               scan_start;
    logic               scan_valid;
    logic               scan_ready;
    logic [AW-1:0]      scan_idx;
    logic [DW-1:0]      scan_data;
    logic               scan_done;
    logic               busy;
    logic               sel_ena;
    logic [AW-1:0]      sel_idx;
    logic [DW-1:0]      sel_data;

    regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .scan_start(scan_start), .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_idx(scan_idx), .scan_data(scan_data), .scan_done(scan_done),
        .busy(busy), .sel_ena(sel_ena), .sel_idx(sel_idx), .sel_data(sel_data)
    );

    always #5 clk = ~clk;

    // Selector model: entry k holds A500_0000+k; a disabled selector returns garbage.
    assign sel_data = sel_ena ? (ENTRY_BASE + DW'(sel_idx)) : 32'hDEAD_BEEF;

    int testsRun = 0;
    int testsFailed = 0;

    logic [NREQ-1:0] autoReq;
    int              fixedAddr [NREQ];
    bit              randMode;
    int              readyMode;
    logic [NREQ-1:0] lastRsp;

    int              cyc = 0;
    logic [NREQ-1:0] hist [8];
    int              modelLast = NREQ - 1;
    int              scanExpect = 0;
    bit              doneDue = 1'b0;
    bit              prevValid = 1'b0;
    bit              prevReady = 1'b0;
    logic [AW-1:0]   prevIdx;
    logic [DW-1:0]   prevData;
    int              rspTotal = 0, beatTotal = 0, doneTotal = 0, selCycles = 0;
    int              rspCycle = 0, doneCycle = 0;
    logic [NREQ-1:0] lastRspVec;
    logic [DW-1:0]   lastRspData;
    int              age [NREQ];
    int              obsGnt, expGnt;

    int              got, idle;
    bit              found;
    int              fairOrder [4];
    logic [DW-1:0]   fairData [4];

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int rrExpect(input logic [NREQ-1:0] elig, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (elig[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock of stimulus: requesters drop after their response and re-raise when enabled.
    task automatic applyStimulus(input bit startPulse);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && lastRsp[i]) begin
                req_valid[i] = 1'b0;
            end else if (!req_valid[i] && !lastRsp[i] && autoReq[i] &&
                         (!randMode || $urandom_range(0, 3) == 0)) begin
                req_valid[i] = 1'b1;
                req_addr[i*AW +: AW] = randMode ? AW'($urandom_range(0, 31)) : AW'(fixedAddr[i]);
            end
        end
        scan_start = startPulse || (randMode && $urandom_range(0, 79) == 0);
        case (readyMode)
            0:       scan_ready = 1'b1;
            1:       scan_ready = ~scan_ready;
            default: scan_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        scan_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        hist[cyc % 8] = req_valid & ~rsp_valid;
        lastRsp = rsp_valid;
        if (rst) begin
            modelLast = NREQ - 1;
            scanExpect = 0;
            doneDue = 1'b0;
            prevValid = 1'b0;
            prevReady = 1'b0;
            rspTotal = 0;
            beatTotal = 0;
            doneTotal = 0;
            selCycles = 0;
            for (int i = 0; i < NREQ; i++) age[i] = 0;
        end else begin
            if (sel_ena) selCycles++;
            for (int i = 0; i < NREQ; i++) if (req_valid[i]) age[i]++;

            if (rsp_valid != '0) begin
                obsGnt = -1;
                for (int i = 0; i < NREQ; i++) if (rsp_valid[i] && obsGnt < 0) obsGnt = i;
                expGnt = rrExpect(hist[(cyc - 2) % 8], modelLast);
                checkOutput("rspOneHot", 64'($countones(rsp_valid)), 64'd1);
                checkOutput("rrGrant", 64'(obsGnt), 64'(expGnt));
                checkOutput("rspData", rsp_data, ENTRY_BASE + DW'(req_addr[obsGnt*AW +: AW]));
                checkOutput("rspWait", 64'(age[obsGnt] <= 2000), 64'd1);
                age[obsGnt] = 0;
                modelLast = obsGnt;
                rspTotal++;
                rspCycle = cyc;
                lastRspVec = rsp_valid;
                lastRspData = rsp_data;
            end

            if (scan_done || doneDue) checkOutput("scanDone", scan_done, doneDue);
            if (scan_done) begin
                doneTotal++;
                doneCycle = cyc;
            end
            doneDue = 1'b0;

            if (scan_valid) begin
                if (prevValid && !prevReady) begin
                    checkOutput("scanHoldIdx", scan_idx, prevIdx);
                    checkOutput("scanHoldData", scan_data, prevData);
                end
                checkOutput("scanIdx", scan_idx, 64'(scanExpect));
                checkOutput("scanData", scan_data, ENTRY_BASE + DW'(scanExpect));
                if (scan_ready) begin
                    beatTotal++;
                    if (scanExpect == 31) begin
                        doneDue = 1'b1;
                        scanExpect = 0;
                    end else begin
                        scanExpect++;
                    end
                end
            end else if (prevValid && !prevReady) begin
                checkOutput("scanHoldValid", scan_valid, 1'b1);
            end
            prevValid = scan_valid;
            prevReady = scan_ready;
            prevIdx = scan_idx;
            prevData = scan_data;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        scan_start = 1'b0;
        scan_ready = 1'b0;
        autoReq = '0;
        randMode = 1'b0;
        readyMode = 0;
        lastRsp = '0;
        for (int i = 0; i < NREQ; i++) fixedAddr[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstRspValid", rsp_valid, 0);
        checkOutput("rstRspData", rsp_data, 0);
        checkOutput("rstScanValid", scan_valid, 0);
        checkOutput("rstScanIdx", scan_idx, 0);
        checkOutput("rstScanData", scan_data, 0);
        checkOutput("rstScanDone", scan_done, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstSelEna", sel_ena, 0);
        checkOutput("rstSelIdx", sel_idx, 0);

        // Single request: response exactly two cycles after the request is seen.
        autoReq = 4'b0001;
        fixedAddr[0] = 7;
        applyStimulus(1'b0);
        autoReq = '0;
        @(negedge clk);
        checkOutput("single.t0", rsp_valid, 0);
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("single.t1", rsp_valid, 0);
        checkOutput("single.selEna", sel_ena, 1);
        checkOutput("single.selIdx", sel_idx, 7);
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("single.t2", rsp_valid, 4'b0001);
        checkOutput("single.data", rsp_data, 32'hA500_0007);

        // Fairness between two continuously requesting readers.
        doReset();
        autoReq = 4'b0101;
        fixedAddr[0] = 3;
        fixedAddr[2] = 31;
        got = 0;
        for (int n = 0; n < 60 && got < 4; n++) begin
            applyStimulus(1'b0);
            @(negedge clk);
            if (rsp_valid != '0) begin
                fairOrder[got] = rsp_valid[0] ? 0 : (rsp_valid[2] ? 2 : 9);
                fairData[got] = rsp_data;
                got++;
            end
        end
        autoReq = '0;
        checkOutput("fair.count", 64'(got), 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("fair.order", 64'(fairOrder[k]), (k % 2 == 0) ? 0 : 2);
            checkOutput("fair.data", fairData[k], (k % 2 == 0) ? 32'hA500_0003 : 32'hA500_001F);
        end

        // Scan with toggling backpressure.
        doReset();
        readyMode = 1;
        applyStimulus(1'b1);
        for (int n = 0; n < 400 && doneTotal == 0; n++) applyStimulus(1'b0);
        checkOutput("scan.done", 64'(doneTotal), 1);
        checkOutput("scan.beats", 64'(beatTotal), 32);
        repeat (10) applyStimulus(1'b0);
        checkOutput("scan.oneDone", 64'(doneTotal), 1);

        // Scan start and a request in the same cycle: scan goes first.
        doReset();
        readyMode = 0;
        autoReq = 4'b0010;
        fixedAddr[1] = 5;
        applyStimulus(1'b1);
        autoReq = '0;
        for (int n = 0; n < 300 && rspTotal == 0; n++) applyStimulus(1'b0);
        checkOutput("coll.rspCount", 64'(rspTotal), 1);
        checkOutput("coll.scanFirst", 64'(doneTotal), 1);
        checkOutput("coll.beats", 64'(beatTotal), 32);
        checkOutput("coll.rspVec", lastRspVec, 4'b0010);
        checkOutput("coll.rspData", lastRspData, 32'hA500_0005);
        checkOutput("coll.latency", 64'(rspCycle), 64'(doneCycle + 2));

        // Reset in the middle of a scan, then a fresh scan from index 0.
        doReset();
        readyMode = 0;
        applyStimulus(1'b1);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            applyStimulus(1'b0);
            @(negedge clk);
            if (scan_valid && scan_idx == 12) found = 1'b1;
        end
        checkOutput("abort.reached12", 64'(found), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        scan_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort.scanValid", scan_valid, 0);
        checkOutput("abort.busy", busy, 0);
        checkOutput("abort.selEna", sel_ena, 0);
        repeat (20) applyStimulus(1'b0);
        checkOutput("abort.noDone", 64'(doneTotal), 0);
        applyStimulus(1'b1);
        for (int n = 0; n < 300 && doneTotal == 0; n++) applyStimulus(1'b0);
        checkOutput("rescan.done", 64'(doneTotal), 1);
        checkOutput("rescan.beats", 64'(beatTotal), 32);

        // Selector enable stays low when idle and is used once per read.
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b0);
            @(negedge clk);
            checkOutput("idle.selEna", sel_ena, 0);
        end
        checkOutput("selEna.cycles", 64'(selCycles), 64'(rspTotal + beatTotal));

        // Randomized traffic with random scans and backpressure.
        doReset();
        randMode = 1'b1;
        autoReq = '1;
        readyMode = 2;
        repeat (2500) applyStimulus(1'b0);
        randMode = 1'b0;
        autoReq = '0;
        readyMode = 0;
        idle = 0;
        for (int n = 0; n < 3000 && idle < 4; n++) begin
            applyStimulus(1'b0);
            @(negedge clk);
            idle = (!busy && req_valid == '0 && !sel_ena && rsp_valid == '0) ? idle + 1 : 0;
        end
        checkOutput("rand.drained", 64'(idle >= 4), 1);
        checkOutput("rand.selCycles", 64'(selCycles), 64'(rspTotal + beatTotal));
        checkOutput("rand.beatsPerScan", 64'(beatTotal), 64'(32 * doneTotal));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
